// File: rtl/branch_resolve_bp_if.sv
// Resolve-stage bus for branch_resolve_bp: fetch-side predictor read port,
// execute-side resolve request, registered resolution results and statistics.
interface branch_resolve_bp_if #(
    parameter int IDX_W = 4,
    parameter int CNT_W = 16
);
    // fetch-stage predictor read
    logic [IDX_W-1:0] pred_idx;
    logic             pred_taken;

    // resolve request
    logic             res_valid;
    logic [IDX_W-1:0] res_idx;
    logic             res_bl;
    logic             res_comb;
    logic             res_tf;
    logic [2:0]       res_c;
    logic [3:0]       res_flags;
    logic             res_n;
    logic             res_pred;
    logic             flush;

    // registered resolution results
    logic             jump;
    logic             nullify;
    logic             mispredict;
    logic             out_valid;

    // statistics
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] mispred_cnt;

    // pipeline side: drives requests, consumes results
    modport master (
        output pred_idx,
        input  pred_taken,
        output res_valid, res_idx, res_bl, res_comb, res_tf,
        output res_c, res_flags, res_n, res_pred, flush,
        input  jump, nullify, mispredict, out_valid,
        input  branch_cnt, mispred_cnt
    );

    // resolve unit side
    modport slave (
        input  pred_idx,
        output pred_taken,
        input  res_valid, res_idx, res_bl, res_comb, res_tf,
        input  res_c, res_flags, res_n, res_pred, flush,
        output jump, nullify, mispredict, out_valid,
        output branch_cnt, mispred_cnt
    );
endinterface

// File: rtl/branch_resolve_bp.sv
// Execute-stage branch condition and resolution unit with a direct-mapped
// table of 2-bit saturating predictors and saturating statistics counters.
// Resolution outputs are registered and last a single cycle.
module branch_resolve_bp #(
    parameter int IDX_W = 4,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    branch_resolve_bp_if.slave bus
);
    localparam int DEPTH = 2 ** IDX_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0] pht [DEPTH];

    logic       accept;
    logic       is_branch;
    logic       cond;
    logic       taken;
    logic       mis;
    logic       train;
    logic [1:0] pht_cur;
    logic [1:0] pht_nxt;

    // Predictor read; held low during reset so fetch never sees a stale entry
    always_comb begin
        bus.pred_taken = ~reset & pht[bus.pred_idx][1];
    end

    // Compare condition from {Z,N,C,V}
    always_comb begin
        cond = 1'b0;
        case (bus.res_c)
            3'b000:  cond = 1'b0;
            3'b001:  cond = bus.res_flags[3];
            3'b010:  cond = bus.res_flags[2] ^ bus.res_flags[0];
            3'b011:  cond = (bus.res_flags[2] ^ bus.res_flags[0]) | bus.res_flags[3];
            3'b100:  cond = bus.res_flags[1];
            3'b101:  cond = bus.res_flags[1] | bus.res_flags[3];
            3'b110:  cond = bus.res_flags[0];
            3'b111:  cond = ~bus.res_flags[3];
            default: cond = 1'b0;
        endcase
    end

    // Branch resolution; BL wins over COMB, non-branches mispredict if predicted taken
    always_comb begin
        accept    = bus.res_valid & ~bus.flush;
        is_branch = bus.res_bl | bus.res_comb;
        taken     = bus.res_bl | (bus.res_comb & (cond ^ bus.res_tf));
        mis       = is_branch ? (taken ^ bus.res_pred) : bus.res_pred;
        train     = accept & bus.res_comb & ~bus.res_bl;
    end

    // Saturating update of the entry that produced the prediction
    always_comb begin
        pht_cur = pht[bus.res_idx];
        pht_nxt = pht_cur;
        if (taken) begin
            if (pht_cur != 2'b11) pht_nxt = pht_cur + 2'd1;
        end else begin
            if (pht_cur != 2'b00) pht_nxt = pht_cur - 2'd1;
        end
    end

    // Registered resolution results, one cycle after accept
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.out_valid  <= 1'b0;
            bus.jump       <= 1'b0;
            bus.nullify    <= 1'b0;
            bus.mispredict <= 1'b0;
        end else begin
            bus.out_valid  <= accept;
            bus.jump       <= accept & taken;
            bus.nullify    <= accept & taken & bus.res_n;
            bus.mispredict <= accept & mis;
        end
    end

    // Predictor table; entries start weakly not-taken
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pht[i] <= 2'b01;
            end
        end else if (train) begin
            pht[bus.res_idx] <= pht_nxt;
        end
    end

    // Statistics counters, holding at all-ones
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.branch_cnt  <= '0;
            bus.mispred_cnt <= '0;
        end else begin
            if (accept && is_branch && bus.branch_cnt != CNT_MAX) begin
                bus.branch_cnt <= bus.branch_cnt + 1'b1;
            end
            if (accept && mis && bus.mispred_cnt != CNT_MAX) begin
                bus.mispred_cnt <= bus.mispred_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_branch_resolve_bp.sv
// Bench for branch_resolve_bp: directed vectors, a behavioural model checked
// every negative edge, and literal expectations at key points. A second
// instance with 2-bit counters shares the stimulus to exercise saturation.
module tb_branch_resolve_bp;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    branch_resolve_bp_if #(.IDX_W(4), .CNT_W(16)) bif ();
    branch_resolve_bp_if #(.IDX_W(4), .CNT_W(2))  bif2 ();

    assign bif2.pred_idx  = bif.pred_idx;
    assign bif2.res_valid = bif.res_valid;
    assign bif2.res_idx   = bif.res_idx;
    assign bif2.res_bl    = bif.res_bl;
    assign bif2.res_comb  = bif.res_comb;
    assign bif2.res_tf    = bif.res_tf;
    assign bif2.res_c     = bif.res_c;
    assign bif2.res_flags = bif.res_flags;
    assign bif2.res_n     = bif.res_n;
    assign bif2.res_pred  = bif.res_pred;
    assign bif2.flush     = bif.flush;

    branch_resolve_bp #(.IDX_W(4), .CNT_W(16)) dut (.clk(clk), .reset(reset), .bus(bif.slave));
    branch_resolve_bp #(.IDX_W(4), .CNT_W(2))  dut2 (.clk(clk), .reset(reset), .bus(bif2.slave));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int mtab [16];
    int m_br, m_mis;
    bit m_ov, m_j, m_nul, m_mp;

    function automatic bit spec_cond(input int c, input logic [3:0] f);
        bit z, n, cy, v, lt;
        z = f[3]; n = f[2]; cy = f[1]; v = f[0];
        lt = (n != v);
        case (c)
            1: return z;
            2: return lt;
            3: return lt || z;
            4: return cy;
            5: return cy || z;
            6: return v;
            7: return !z;
            default: return 0;
        endcase
    endfunction

    function automatic int sat(input int v, input int w);
        int cap;
        cap = (1 << w) - 1;
        return (v > cap) ? cap : v;
    endfunction

    always @(posedge clk or posedge reset) begin
        bit acc, tk, mis;
        if (reset) begin
            for (int i = 0; i < 16; i++) mtab[i] = 1;
            m_br = 0; m_mis = 0;
            m_ov = 0; m_j = 0; m_nul = 0; m_mp = 0;
        end else begin
            acc = bif.res_valid && !bif.flush;
            if (bif.res_bl) tk = 1;
            else if (bif.res_comb) tk = (spec_cond(int'(bif.res_c), bif.res_flags) != bif.res_tf);
            else tk = 0;
            if (bif.res_bl || bif.res_comb) mis = (tk != bif.res_pred);
            else mis = bif.res_pred;
            m_ov  = acc;
            m_j   = acc && tk;
            m_nul = acc && tk && bif.res_n;
            m_mp  = acc && mis;
            if (acc && bif.res_comb && !bif.res_bl) begin
                if (tk) mtab[bif.res_idx] = (mtab[bif.res_idx] < 3) ? mtab[bif.res_idx] + 1 : 3;
                else    mtab[bif.res_idx] = (mtab[bif.res_idx] > 0) ? mtab[bif.res_idx] - 1 : 0;
            end
            if (acc && (bif.res_bl || bif.res_comb)) m_br++;
            if (acc && mis) m_mis++;
        end
    end

    // Compare every cycle, away from the active edge
    always @(negedge clk) begin
        bit exp_pt;
        exp_pt = !reset && (mtab[bif.pred_idx] >= 2);
        check("out_valid",   bif.out_valid,    m_ov);
        check("jump",        bif.jump,         m_j);
        check("nullify",     bif.nullify,      m_nul);
        check("mispredict",  bif.mispredict,   m_mp);
        check("pred_taken",  bif.pred_taken,   exp_pt);
        check("branch_cnt",  bif.branch_cnt,   sat(m_br, 16));
        check("mispred_cnt", bif.mispred_cnt,  sat(m_mis, 16));
        check("branch_cnt2", bif2.branch_cnt,  sat(m_br, 2));
        check("mispred_cnt2", bif2.mispred_cnt, sat(m_mis, 2));
        check("out_valid2",  bif2.out_valid,   m_ov);
        check("pred_taken2", bif2.pred_taken,  exp_pt);
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        bif.res_valid = 0; bif.flush = 0; bif.res_bl = 0; bif.res_comb = 0;
        bif.res_tf = 0; bif.res_c = 3'b000; bif.res_flags = 4'b0000;
        bif.res_n = 0; bif.res_pred = 0; bif.res_idx = '0;
    endtask

    task automatic set_req(input bit bl, input bit comb, input bit tf, input logic [2:0] c,
                           input logic [3:0] f, input bit n, input bit pred,
                           input logic [3:0] idx, input bit fl);
        bif.res_valid = 1; bif.flush = fl; bif.res_bl = bl; bif.res_comb = comb;
        bif.res_tf = tf; bif.res_c = c; bif.res_flags = f; bif.res_n = n;
        bif.res_pred = pred; bif.res_idx = idx;
    endtask

    // Present one request across one edge, then go idle; returns at edge+2
    task automatic issue(input bit bl, input bit comb, input bit tf, input logic [2:0] c,
                         input logic [3:0] f, input bit n, input bit pred,
                         input logic [3:0] idx, input bit fl);
        set_req(bl, comb, tf, c, f, n, pred, idx, fl);
        @(posedge clk); #2;
        idle();
    endtask

    initial begin
        reset = 1;
        bif.pred_idx = '0;
        idle();
        repeat (3) @(posedge clk);
        #2 reset = 0;

        // reset state: every entry weakly not-taken
        for (int i = 0; i < 16; i++) begin
            bif.pred_idx = 4'(i);
            #1 check("reset_pred_taken", bif.pred_taken, 0);
            @(posedge clk); #2;
        end
        check("reset_branch_cnt", bif.branch_cnt, 0);
        check("reset_out_valid", bif.out_valid, 0);

        // taken COMB on Z, predicted not-taken, nullify set
        bif.pred_idx = 4'd5;
        set_req(0, 1, 0, 3'b001, 4'b1000, 1, 0, 4'd5, 0);
        #1 check("old_value_in_accept_cycle", bif.pred_taken, 0);
        @(posedge clk); #2; idle();
        check("t2_jump", bif.jump, 1);
        check("t2_nullify", bif.nullify, 1);
        check("t2_mispredict", bif.mispredict, 1);
        check("t2_out_valid", bif.out_valid, 1);
        check("t2_pred_taken", bif.pred_taken, 1);

        // saturate at 11, then one not-taken drops to 10
        repeat (3) issue(0, 1, 0, 3'b001, 4'b1000, 0, 1, 4'd5, 0);
        check("t3_pred_taken_sat", bif.pred_taken, 1);
        issue(0, 1, 0, 3'b111, 4'b1000, 0, 1, 4'd5, 0);
        check("t3_jump_nt", bif.jump, 0);
        check("t3_mispredict_nt", bif.mispredict, 1);
        check("t3_pred_taken_10", bif.pred_taken, 1);

        // BL with COMB: BL wins, table untouched
        bif.pred_idx = 4'd7;
        issue(1, 1, 0, 3'b000, 4'b0000, 0, 1, 4'd7, 0);
        check("t4_jump", bif.jump, 1);
        check("t4_mispredict", bif.mispredict, 0);
        check("t4_branch_cnt", bif.branch_cnt, 6);
        check("t4_pred_taken", bif.pred_taken, 0);

        // flushed request: nothing happens
        issue(0, 1, 0, 3'b100, 4'b0010, 0, 0, 4'd7, 1);
        check("t5_out_valid", bif.out_valid, 0);
        check("t5_jump", bif.jump, 0);
        check("t5_branch_cnt", bif.branch_cnt, 6);
        check("t5_mispred_cnt", bif.mispred_cnt, 2);
        check("t5_pred_taken", bif.pred_taken, 0);

        // four non-branch mispredicts: 2-bit counter holds at 3
        repeat (4) issue(0, 0, 0, 3'b000, 4'b0000, 0, 1, 4'd1, 0);
        check("t6_mispred_cnt", bif.mispred_cnt, 6);
        check("t6_mispred_cnt2", bif2.mispred_cnt, 3);
        check("t6_branch_cnt2", bif2.branch_cnt, 3);

        // every condition code against several flag patterns, back to back
        for (int f = 0; f < 16; f += 5) begin
            for (int c = 0; c < 8; c++) begin
                bif.pred_idx = 4'(c + 8);
                set_req(0, 1, c[0] ^ f[1], 3'(c), 4'(f), f[0], c[1], 4'(c + 8), 0);
                @(posedge clk); #2;
            end
        end
        idle();
        @(posedge clk); #2;
        check("btb_idle_out_valid", bif.out_valid, 0);

        // reset in mid-cycle with a request pending
        bif.pred_idx = 4'd3;
        issue(0, 1, 0, 3'b001, 4'b1000, 1, 0, 4'd3, 0);
        check("t7_pre_out_valid", bif.out_valid, 1);
        check("t7_pre_pred_taken", bif.pred_taken, 1);
        set_req(0, 1, 0, 3'b001, 4'b1000, 1, 0, 4'd3, 0);
        #1 reset = 1;
        #1;
        check("t7_async_out_valid", bif.out_valid, 0);
        check("t7_async_jump", bif.jump, 0);
        check("t7_async_nullify", bif.nullify, 0);
        check("t7_async_mispredict", bif.mispredict, 0);
        check("t7_async_pred_taken", bif.pred_taken, 0);
        check("t7_async_branch_cnt", bif.branch_cnt, 0);
        @(posedge clk); #2;
        idle();
        reset = 0;
        #1 check("t7_table_untrained", bif.pred_taken, 0);
        check("t7_mispred_cnt", bif.mispred_cnt, 0);
        repeat (3) @(posedge clk);
        #2;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
